// File: rtl/serial_pkg.sv
// Shared constants for the serial transmitter: FSM encoding and line levels.
package serial_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/tx_shift_reg.sv
// Parallel-load, shift-right payload register; sout is the bit due out next.
module tx_shift_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic              shift_en,
  input  logic [DATA_W-1:0] d,
  output logic              sout
);

  logic [DATA_W-1:0] sh_d, sh_q;

  always_comb begin
    sh_d = sh_q;
    if (load_en)       sh_d = d;
    else if (shift_en) sh_d = sh_q >> 1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) sh_q <= '0;
    else        sh_q <= sh_d;
  end

  assign sout = sh_q[0];

endmodule

// File: rtl/serial_tx.sv
// Start/data/parity/stop serial transmitter with a registered TXD line.
module serial_tx
  import serial_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int PARITY_EN = 1
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic [DATA_W-1:0] D,
  input  logic              LOAD,
  output logic              READY,
  output logic              TXD,
  output logic              DONE
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  logic [2:0]       state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             par_d, par_q;
  logic             txd_d, txd_q;
  logic             done_d, done_q;
  logic             load_en, shift_en, sh_bit;

  tx_shift_reg #(.DATA_W(DATA_W)) u_shreg (
    .clk      (CLK),
    .rst_n    (RST_n),
    .load_en  (load_en),
    .shift_en (shift_en),
    .d        (D),
    .sout     (sh_bit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    load_en = 1'b0;
    case (state_q)
      ST_IDLE: if (LOAD) begin
        state_d = ST_START;
        load_en = 1'b1;
        par_d   = ^D;
        cnt_d   = '0;
      end
      ST_START: begin
        state_d = ST_DATA;
        cnt_d   = '0;
      end
      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_PARITY: state_d = ST_STOP;
      ST_STOP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // TXD is registered from the next state, so a data bit is consumed from
  // the shift register on the same edge that moves it onto the line.
  assign shift_en = (state_d == ST_DATA);

  always_comb begin
    case (state_d)
      ST_START:  txd_d = START_BIT;
      ST_DATA:   txd_d = sh_bit;
      ST_PARITY: txd_d = par_q;
      ST_STOP:   txd_d = STOP_BIT;
      default:   txd_d = IDLE_LEVEL;
    endcase
    done_d = (state_d == ST_STOP);
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      txd_q   <= IDLE_LEVEL;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
      done_q  <= done_d;
    end
  end

  assign READY = (state_q == ST_IDLE);
  assign TXD   = txd_q;
  assign DONE  = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: parity and no-parity instances share stimulus, a frame-queue model checks every cycle.
module tb_serial_tx;

  localparam int DW = 8;

  logic          CLK = 1'b0;
  logic          RST_n;
  logic          LOAD;
  logic [DW-1:0] D;
  logic          rdy_p, txd_p, done_p;
  logic          rdy_n, txd_n, done_n;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 CLK = ~CLK;

  serial_tx #(.DATA_W(DW), .PARITY_EN(1)) dut_p (
    .CLK(CLK), .RST_n(RST_n), .D(D), .LOAD(LOAD),
    .READY(rdy_p), .TXD(txd_p), .DONE(done_p)
  );

  serial_tx #(.DATA_W(DW), .PARITY_EN(0)) dut_n (
    .CLK(CLK), .RST_n(RST_n), .D(D), .LOAD(LOAD),
    .READY(rdy_n), .TXD(txd_n), .DONE(done_n)
  );

  task automatic check(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a frame is just a list of line bits; the line shows the head of
  // the list, pops one per cycle, and a new list is only taken when empty.
  function automatic logic [19:0] frame_of(input logic [DW-1:0] d, input bit pen);
    logic [19:0] f;
    f = '0;
    f[0] = 1'b0;
    for (int i = 0; i < DW; i++) f[1+i] = d[i];
    if (pen) begin
      f[DW+1] = ^d;
      f[DW+2] = 1'b1;
    end else begin
      f[DW+1] = 1'b1;
    end
    return f;
  endfunction

  int          rem_p = 0, rem_n = 0;
  logic [19:0] bits_p = '0, bits_n = '0;

  always @(posedge CLK) begin
    if (!RST_n) begin
      rem_p = 0;
      rem_n = 0;
    end else begin
      if (rem_p > 0) begin bits_p = bits_p >> 1; rem_p--; end
      else if (LOAD) begin bits_p = frame_of(D, 1'b1); rem_p = DW + 3; end
      if (rem_n > 0) begin bits_n = bits_n >> 1; rem_n--; end
      else if (LOAD) begin bits_n = frame_of(D, 1'b0); rem_n = DW + 2; end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      check("model_txd_p",   txd_p,  (rem_p == 0) ? 1'b1 : bits_p[0]);
      check("model_ready_p", rdy_p,  rem_p == 0);
      check("model_done_p",  done_p, rem_p == 1);
      check("model_txd_n",   txd_n,  (rem_n == 0) ? 1'b1 : bits_n[0]);
      check("model_ready_n", rdy_n,  rem_n == 0);
      check("model_done_n",  done_n, rem_n == 1);
    end
  end

  // Hand-written line sequence for one frame, starting at the current negedge.
  task automatic expect_frame(input string nm, input string seq, input bit on_p);
    int len;
    len = seq.len();
    for (int i = 0; i < len; i++) begin
      check({nm, "_txd"},   on_p ? txd_p  : txd_n,  seq.getc(i) == "1");
      check({nm, "_done"},  on_p ? done_p : done_n, i == len - 1);
      check({nm, "_ready"}, on_p ? rdy_p  : rdy_n,  1'b0);
      @(negedge CLK);
    end
  endtask

  task automatic pulse_load(input logic [DW-1:0] val);
    @(negedge CLK);
    D = val;
    LOAD = 1'b1;
    @(negedge CLK);
    LOAD = 1'b0;
  endtask

  task automatic idle_gap(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    RST_n = 1'b0;
    LOAD  = 1'b0;
    D     = '0;
    repeat (2) @(negedge CLK);
    check("rst_txd", txd_p, 1'b1);
    check("rst_ready", rdy_p, 1'b1);
    check("rst_done", done_p, 1'b0);
    chk_en = 1'b1;
    RST_n = 1'b1;
    idle_gap(2);

    // A5 on both line formats
    pulse_load(8'hA5);
    fork
      expect_frame("a5_p", "01010010101", 1'b1);
      expect_frame("a5_n", "0101001011", 1'b0);
    join
    idle_gap(3);

    pulse_load(8'h01);
    expect_frame("x01_p", "01000000011", 1'b1);
    idle_gap(3);

    pulse_load(8'hFF);
    fork
      expect_frame("ff_p", "01111111101", 1'b1);
      expect_frame("ff_n", "0111111111", 1'b0);
    join
    idle_gap(3);

    // LOAD and D activity mid-frame must not disturb or retrigger
    pulse_load(8'hA5);
    fork
      expect_frame("ign_p", "01010010101", 1'b1);
      begin
        idle_gap(3);
        LOAD = 1'b1;
        D = 8'h3C;
        idle_gap(3);
        LOAD = 1'b0;
      end
    join
    idle_gap(3);
    check("ign_idle_txd", txd_p, 1'b1);
    check("ign_idle_ready", rdy_p, 1'b1);
    idle_gap(3);

    // reset during the 4th payload bit
    pulse_load(8'hA5);
    idle_gap(4);
    RST_n = 1'b0;
    @(negedge CLK);
    check("abort_txd", txd_p, 1'b1);
    check("abort_ready", rdy_p, 1'b1);
    check("abort_done", done_p, 1'b0);
    RST_n = 1'b1;
    pulse_load(8'h5A);
    fork
      expect_frame("x5a_p", "00101101001", 1'b1);
      expect_frame("x5a_n", "0010110101", 1'b0);
    join
    idle_gap(3);

    // LOAD held: back-to-back frames with one idle cycle between
    @(negedge CLK);
    D = 8'hA5;
    LOAD = 1'b1;
    @(negedge CLK);
    fork
      begin
        expect_frame("b2b1_p", "01010010101", 1'b1);
        check("b2b_gap_txd", txd_p, 1'b1);
        check("b2b_gap_ready", rdy_p, 1'b1);
        check("b2b_gap_done", done_p, 1'b0);
        @(negedge CLK);
        expect_frame("b2b2_p", "01111000001", 1'b1);
      end
      begin
        idle_gap(5);
        D = 8'h0F;
        idle_gap(10);
        LOAD = 1'b0;
      end
    join
    idle_gap(15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
